// File: rtl/dl_demux32_stream.sv
// dl_demux32_stream
//   Two-entry in-order buffer that steers each beat to one of 32 destinations.
//   Every beat carries a 5-bit destination index. The head beat is offered on a
//   shared data bus, with a one-hot valid on its destination. Only that
//   destination's ready can pop it, so a stalled head blocks the beats behind it.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   in_valid    upstream beat present
//   in_ready    registered accept; depends only on state, never on inputs
//   in_data     payload (NUM_BITS)
//   in_sel      destination index 0..31
//   out_valid   one-hot valid of the head beat, zero when empty
//   out_ready   per-destination ready; only the head's bit matters
//   out_data    head payload, holds its last value when empty
//   out_sel     head destination, holds its last value when empty
//   flush       drop all buffered beats (a pop this cycle still completes)
//   beat_count  wrapping count of completed output transfers
module dl_demux32_stream #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic [4:0]          in_sel,
  output logic [31:0]         out_valid,
  input  logic [31:0]         out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic [4:0]          out_sel,
  input  logic                flush,
  output logic [15:0]         beat_count
);

  logic [NUM_BITS-1:0] r_data [2];
  logic [4:0]          r_sel  [2];
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_count;
  logic                r_in_ready;
  logic [31:0]         r_out_valid;
  logic [NUM_BITS-1:0] r_out_data;
  logic [4:0]          r_out_sel;
  logic [15:0]         r_beat_count;

  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_count_nxt;
  logic                w_rd_ptr_nxt;
  logic [NUM_BITS-1:0] w_head_data_nxt;
  logic [4:0]          w_head_sel_nxt;

  assign w_push = in_valid & r_in_ready & ~flush;
  // r_out_valid is one-hot on the head's destination and zero when empty, so
  // this is "not empty and the head's own ready bit is set".
  assign w_pop  = |(r_out_valid & out_ready);

  always_comb begin
    w_count_nxt     = r_count;
    w_rd_ptr_nxt    = r_rd_ptr ^ w_pop;
    w_head_data_nxt = r_data[w_rd_ptr_nxt];
    w_head_sel_nxt  = r_sel[w_rd_ptr_nxt];
    if (flush) begin
      w_count_nxt = 2'd0;
    end else begin
      w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
    // If the beat being written now becomes the new head, it is not yet in
    // storage, so take it straight from the input.
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_data_nxt = in_data;
      w_head_sel_nxt  = in_sel;
    end
  end

  // Storage needs no reset; r_count decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_data[r_wr_ptr] <= in_data;
      r_sel[r_wr_ptr]  <= in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 32'd0;
      r_out_data   <= '0;
      r_out_sel    <= 5'd0;
      r_beat_count <= 16'd0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2) && !flush;
      if (w_pop) begin
        r_beat_count <= r_beat_count + 16'd1;
      end
      if (flush) begin
        r_rd_ptr    <= 1'b0;
        r_wr_ptr    <= 1'b0;
        r_out_valid <= 32'd0;
      end else begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_wr_ptr <= r_wr_ptr ^ w_push;
        if (w_count_nxt != 2'd0) begin
          r_out_valid <= 32'd1 << w_head_sel_nxt;
          r_out_data  <= w_head_data_nxt;
          r_out_sel   <= w_head_sel_nxt;
        end else begin
          r_out_valid <= 32'd0;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sel    = r_out_sel;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_dl_demux32_stream.sv
// Directed bench for dl_demux32_stream with a queue scoreboard of expected beats.
module tb_dl_demux32_stream;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  sel;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_sel;
  logic [31:0] out_valid;
  logic [31:0] out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_sel;
  logic        flush;
  logic [15:0] beat_count;

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  beat_t       q[$];
  logic [15:0] exp_bc  = 16'd0;
  logic        exp_rdy = 1'b0;

  dl_demux32_stream #(.NUM_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .flush     (flush),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the DUT against the model, predict the coming edge, then advance
  // to just after that edge.
  task automatic tick();
    bit    pop;
    bit    push;
    beat_t b;
    if (chk_en) begin
      chk("sb_valid", out_valid, (q.size() > 0) ? (32'd1 << q[0].sel) : 32'd0);
      if (q.size() > 0) begin
        chk("sb_data", out_data, q[0].data);
        chk("sb_sel", {27'd0, out_sel}, {27'd0, q[0].sel});
      end
      chk("sb_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("sb_beat_count", {16'd0, beat_count}, {16'd0, exp_bc});
    end
    pop  = (q.size() > 0) && out_ready[q[0].sel];
    push = in_valid && exp_rdy && !flush;
    if (rst) begin
      q.delete();
      exp_bc  = 16'd0;
      exp_rdy = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        exp_bc = exp_bc + 16'd1;
      end
      if (flush) begin
        q.delete();
      end else if (push) begin
        b.data = in_data;
        b.sel  = in_sel;
        q.push_back(b);
      end
      exp_rdy = (q.size() < 2) && !flush;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] bc0;
    logic [31:0] snap_data;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_sel    = 5'd0;
    out_ready = 32'd0;
    flush     = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;

    // reset state
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", {27'd0, out_sel}, 32'd0);
    chk("rst_beat_count", {16'd0, beat_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single beat
    out_ready = 32'hFFFF_FFFF;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    in_sel    = 5'd5;
    tick();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 32'h0000_0020);
    chk("single_data", out_data, 32'hDEAD_BEEF);
    tick();
    chk("single_empty", out_valid, 32'd0);
    chk("single_bcnt", {16'd0, beat_count}, 32'd1);

    // backpressure fill
    out_ready = 32'd0;
    in_valid  = 1'b1;
    in_data   = 32'h1111_0003;
    in_sel    = 5'd3;
    tick();
    in_data = 32'h2222_001F;
    in_sel  = 5'd31;
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_valid", out_valid, 32'h0000_0008);
    out_ready = 32'h0000_0008;
    tick();
    chk("bp_next_valid", out_valid, 32'h8000_0000);
    chk("bp_next_data", out_data, 32'h2222_001F);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    out_ready = 32'hFFFF_FFFF;
    tick();
    chk("bp_drained", out_valid, 32'd0);

    // selective ready: only bit 7 is withheld
    out_ready = 32'hFFFF_FF7F;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0007;
    in_sel    = 5'd7;
    tick();
    in_valid  = 1'b0;
    snap_data = out_data;
    bc0       = beat_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", out_valid, 32'h0000_0080);
      chk("stall_data", out_data, 32'hA5A5_0007);
      chk("stall_sel", {27'd0, out_sel}, 32'd7);
    end
    chk("stall_snap", out_data, snap_data);
    out_ready = 32'h0000_0080;
    tick();
    chk("stall_pop_bcnt", {16'd0, beat_count}, {16'd0, bc0 + 16'd1});
    chk("stall_pop_empty", out_valid, 32'd0);

    // streaming, one beat per cycle across every destination
    out_ready = 32'hFFFF_FFFF;
    bc0       = beat_count;
    in_valid  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_sel  = 5'(i);
      in_data = $urandom;
      tick();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_valid", out_valid, 32'd1 << i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_bcnt", {16'd0, beat_count}, {16'd0, bc0 + 16'd32});

    // flush of a full FIFO, nothing ready
    out_ready = 32'd0;
    in_valid  = 1'b1;
    in_sel    = 5'd9;
    in_data   = 32'h0000_0909;
    tick();
    in_sel  = 5'd10;
    in_data = 32'h0000_0A0A;
    tick();
    in_valid = 1'b0;
    bc0      = beat_count;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 32'd0);
    chk("flush_bcnt", {16'd0, beat_count}, {16'd0, bc0});
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("flush_in_ready_back", {31'd0, in_ready}, 32'd1);

    // flush while the head pops; the in_valid beat must be refused
    in_valid = 1'b1;
    in_sel   = 5'd12;
    in_data  = 32'h0000_0C0C;
    tick();
    in_sel  = 5'd13;
    in_data = 32'h0000_0D0D;
    tick();
    bc0       = beat_count;
    out_ready = 32'h0000_1000;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_pop_bcnt", {16'd0, beat_count}, {16'd0, bc0 + 16'd1});
    chk("flush_pop_valid", out_valid, 32'd0);
    tick();
    chk("flush_no_push", out_valid, 32'd0);

    // reset of a full FIFO with a handshake pending
    out_ready = 32'd0;
    in_valid  = 1'b1;
    in_sel    = 5'd20;
    in_data   = 32'h0000_1414;
    tick();
    in_sel = 5'd21;
    tick();
    out_ready = 32'hFFFF_FFFF;
    rst       = 1'b1;
    tick();
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst2_bcnt", {16'd0, beat_count}, 32'd0);
    chk("rst2_valid", out_valid, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("rst2_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("rst2_bcnt_held", {16'd0, beat_count}, 32'd0);

    // 65536 pops wrap the transfer counter back to zero
    chk_en   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_sel  = 5'(i);
      in_data = i;
      tick();
    end
    in_valid = 1'b0;
    chk_en   = 1'b1;
    chk("wrap_ffff", {16'd0, beat_count}, 32'h0000_FFFF);
    tick();
    chk("wrap_zero", {16'd0, beat_count}, 32'd0);
    chk("wrap_empty", out_valid, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
